// File: rtl/sh_pkg.sv
// Shared types and slew helper for the multichannel sample-and-hold.
// Used by sh_channel and multichannel_sample_and_hold (optional droop: SH_DROOP_EN).
package sh_pkg;

  // Widest sample the slew helper handles; W must stay strictly below this.
  localparam int SH_MAX_W = 32;

  typedef enum logic {
    SH_TRACK = 1'b0,
    SH_HOLD  = 1'b1
  } sh_state_t;

  // Next tracking cap value: jump to the input when within one step, else move
  // one step toward it. The step never overshoots, so no wrap is possible.
  function automatic logic [SH_MAX_W-1:0] sh_slew_next(
    input logic [SH_MAX_W-1:0] cap,
    input logic [SH_MAX_W-1:0] vin,
    input logic [SH_MAX_W-1:0] step
  );
    logic signed [SH_MAX_W:0] d;
    logic        [SH_MAX_W:0] mag;
    d   = $signed({1'b0, vin}) - $signed({1'b0, cap});
    mag = d[SH_MAX_W] ? $unsigned(-d) : $unsigned(d);
    if (step == '0 || mag <= {1'b0, step}) begin
      sh_slew_next = vin;
    end else if (d[SH_MAX_W]) begin
      sh_slew_next = cap - step;
    end else begin
      sh_slew_next = cap + step;
    end
  endfunction

endpackage

// File: rtl/sh_channel.sv
// One sample-and-hold channel: TRACK/HOLD FSM, slew-limited cap, optional droop.
// The droop counter exists only when SH_DROOP_EN is defined.
module sh_channel
  import sh_pkg::*;
#(
  parameter int W            = 10,
  parameter int SLEW_STEP    = 0,
  parameter int DROOP_PERIOD = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         strobe,
  input  logic [W-1:0] sample_in,
  input  logic         control,
  output logic [W-1:0] cap_out,
  output sh_state_t    state,
  output logic         settled
);

  sh_state_t             state_q;
  sh_state_t             state_next;
  logic [W-1:0]          cap_q;
  logic [W-1:0]          cap_next;
  logic [W-1:0]          cap_track;
  logic [SH_MAX_W-1:0]   slew_full;
  logic [SH_MAX_W-W-1:0] unused_slew_hi;

  assign slew_full      = sh_slew_next(SH_MAX_W'(cap_q), SH_MAX_W'(sample_in),
                                       SH_MAX_W'(SLEW_STEP));
  assign cap_track      = slew_full[W-1:0];
  assign unused_slew_hi = slew_full[SH_MAX_W-1:W];

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SH_TRACK;
    end else begin
      state_q <= state_next;
    end
  end

  // FSM next state: the command only counts on a strobe cycle
  always_comb begin
    state_next = state_q;
    if (strobe) begin
      state_next = control ? SH_HOLD : SH_TRACK;
    end
  end

  // FSM outputs
  always_comb begin
    state   = state_q;
    cap_out = cap_q;
    settled = (state_q == SH_TRACK) && (cap_q == sample_in);
  end

`ifdef SH_DROOP_EN
  localparam int                    DROOP_CW   = $clog2(DROOP_PERIOD) + 1;
  localparam logic [DROOP_CW-1:0]   DROOP_LAST = DROOP_CW'(DROOP_PERIOD - 1);

  logic [DROOP_CW-1:0] droop_cnt;
  logic                droop_tick;

  assign droop_tick = (state_q == SH_HOLD) && (droop_cnt == DROOP_LAST);

  // Counts held cycles; frozen while tracking, restarted on each new hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      droop_cnt <= '0;
    end else if (state_q == SH_TRACK && state_next == SH_HOLD) begin
      droop_cnt <= '0;
    end else if (state_q == SH_HOLD) begin
      droop_cnt <= droop_tick ? '0 : droop_cnt + DROOP_CW'(1);
    end
  end
`else
  localparam int unused_droop_period = DROOP_PERIOD;
`endif

  // Cap update is decided by the state before any transition this cycle.
  always_comb begin
    cap_next = cap_q;
    if (state_q == SH_TRACK) begin
      cap_next = cap_track;
    end
`ifdef SH_DROOP_EN
    if (state_q == SH_HOLD && droop_tick && cap_q != '0) begin
      cap_next = cap_q - W'(1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q <= '0;
    end else begin
      cap_q <= cap_next;
    end
  end

endmodule

// File: rtl/multichannel_sample_and_hold.sv
// N-channel sample-and-hold for the SAR ADC front end, with sys_clk-aligned
// control option. Define SH_DROOP_EN to model held-value droop.
module multichannel_sample_and_hold
  import sh_pkg::*;
#(
  parameter int NCH          = 4,
  parameter int W            = 10,
  parameter int SLEW_STEP    = 0,
  parameter int SYNC_CONTROL = 0,
  parameter int DROOP_PERIOD = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sys_clk,
  input  logic [NCH*W-1:0] input_voltage_real,
  input  logic [NCH-1:0]   input_control_digital,
  output logic [NCH*W-1:0] output_voltage_real,
  output logic [NCH-1:0]   hold_active,
  output logic [NCH-1:0]   settled
);

  logic      prev_sys_clk;
  logic      sys_rise;
  logic      ctl_strobe;
  sh_state_t ch_state [NCH];

  // sys_clk is treated as data; a held-high level yields a single strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_sys_clk <= 1'b0;
    end else begin
      prev_sys_clk <= sys_clk;
    end
  end

  assign sys_rise   = sys_clk & ~prev_sys_clk;
  assign ctl_strobe = (SYNC_CONTROL != 0) ? sys_rise : 1'b1;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    sh_channel #(
      .W            (W),
      .SLEW_STEP    (SLEW_STEP),
      .DROOP_PERIOD (DROOP_PERIOD)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .strobe    (ctl_strobe),
      .sample_in (input_voltage_real[k*W +: W]),
      .control   (input_control_digital[k]),
      .cap_out   (output_voltage_real[k*W +: W]),
      .state     (ch_state[k]),
      .settled   (settled[k])
    );

    assign hold_active[k] = (ch_state[k] == SH_HOLD);
  end

endmodule
